// File: rtl/multi_ch_trig.sv
// multi_ch_trig: per-channel threshold discriminator feeding a k-of-n coincidence and a fixed-length trigger window.
// Latency: a sample above threshold at edge k gives otrig/trig_start after edge k+2 (fire_r stage, coincidence stage, FSM).
// Backpressure: fifo_full blocks new triggers (counted in lost_cnt); an open window is never cut short by it.
// Option: define MULTI_CH_TRIG_RETRIG_EN to let coincidences inside the window extend it (default: ignored).
module multi_ch_trig #(
  parameter int NCH     = 2,
  parameter int DW      = 14,
  parameter int THRES   = 800,
  parameter int TRGTIME = 70,
  parameter int HOLDOFF = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [3:0]        mult,
  input  logic [NCH*DW-1:0] tdat,
  input  logic [NCH*DW-1:0] baseline,
  input  logic              fifo_full,
  output logic              otrig,
  output logic              trig_start,
  output logic [NCH-1:0]    trig_pattern,
  output logic [15:0]       evt_cnt,
  output logic [15:0]       lost_cnt
);

`ifdef MULTI_CH_TRIG_RETRIG_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  localparam logic [DW:0] THRES_V   = THRES[DW:0];
  localparam logic [15:0] WIN_LOAD  = 16'(TRGTIME - 1);
  localparam logic [15:0] HOLD_LOAD = 16'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [NCH-1:0]   fire_now, fire_r;
  logic [NCH-1:0]   pat;
  logic [NCH-1:0]   pat_r;
  logic             coinc, coinc_r;
  logic [DW:0]      diff;
  logic [4:0]       pop;
  logic [3:0]       mult_eff;
  logic             accept, lost, retrig;
  logic [15:0]      win_cnt, hold_cnt;
  logic [15:0]      evt_cnt_q;

  assign evt_cnt = evt_cnt_q;

  // Discriminate each channel: the extra top bit of the difference flags samples below baseline.
  always_comb begin
    fire_now = '0;
    diff     = '0;
    for (int i = 0; i < NCH; i++) begin
      diff        = {1'b0, tdat[i*DW +: DW]} - {1'b0, baseline[i*DW +: DW]};
      fire_now[i] = !diff[DW] && (diff > THRES_V);
    end
  end

  // Count enabled fired channels against the requested multiplicity (0 treated as 1).
  always_comb begin
    pat      = fire_r & ch_mask;
    pop      = '0;
    mult_eff = (mult == 4'd0) ? 4'd1 : mult;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + 5'(pat[i]);
    end
    coinc = (pop >= {1'b0, mult_eff});
  end

  // Two pipeline stages: registered discriminator, then registered coincidence and its pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_r  <= '0;
      coinc_r <= 1'b0;
      pat_r   <= '0;
    end else begin
      fire_r  <= fire_now;
      coinc_r <= coinc;
      pat_r   <= pat;
    end
  end

  // Next-state decode; arm=0 in ARMED wins over a coincidence on the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    lost      = 1'b0;
    retrig    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (coinc_r) begin
          if (fifo_full) begin
            lost = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (RETRIG_EN && coinc_r) begin
          retrig = 1'b1;
        end else if (win_cnt == 16'd0) begin
          if (HOLDOFF == 0) state_nxt = arm ? ARMED : IDLE;
          else              state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == 16'd0) state_nxt = arm ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered window flag and start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      otrig      <= 1'b0;
      trig_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      otrig      <= (state_nxt == ACTIVE);
      trig_start <= accept;
    end
  end

  // Window counter holds the remaining ACTIVE cycles after the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (accept || retrig) begin
      win_cnt <= WIN_LOAD;
    end else if (state == ACTIVE && win_cnt != 16'd0) begin
      win_cnt <= win_cnt - 16'd1;
    end
  end

  // Holdoff counter, loaded as the window closes into HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ACTIVE && state_nxt == HOLD) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == HOLD && hold_cnt != 16'd0) begin
      hold_cnt <= hold_cnt - 16'd1;
    end
  end

  // Event pattern and saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_pattern <= '0;
      evt_cnt_q    <= '0;
      lost_cnt     <= '0;
    end else begin
      if (accept)      trig_pattern <= pat_r;
      else if (retrig) trig_pattern <= trig_pattern | pat_r;
      if (accept && evt_cnt_q != 16'hFFFF) evt_cnt_q <= evt_cnt_q + 16'd1;
      if (lost && lost_cnt != 16'hFFFF)    lost_cnt  <= lost_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_multi_ch_trig.sv
// Directed bench for multi_ch_trig (NCH=2, DW=14, THRES=800, TRGTIME=70, HOLDOFF=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-derived from the trigger timing: pulse sampled at edge e0 -> window after e2.
module tb_multi_ch_trig;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic [1:0]  ch_mask;
  logic [3:0]  mult;
  logic [27:0] tdat;
  logic [27:0] baseline;
  logic        fifo_full;
  logic        otrig;
  logic        trig_start;
  logic [1:0]  trig_pattern;
  logic [15:0] evt_cnt;
  logic [15:0] lost_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULTI_CH_TRIG_RETRIG_EN
  localparam int RETRIG_LEN = 100;
`else
  localparam int RETRIG_LEN = 70;
`endif

  multi_ch_trig dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .ch_mask(ch_mask), .mult(mult),
    .tdat(tdat), .baseline(baseline), .fifo_full(fifo_full),
    .otrig(otrig), .trig_start(trig_start), .trig_pattern(trig_pattern),
    .evt_cnt(evt_cnt), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_samples(input logic [13:0] s0, input logic [13:0] s1);
    tdat = {s1, s0};
  endtask

  task automatic settle();
    for (int i = 0; i < 300 && otrig; i++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (otrig !== 1'b0) begin n_fail++; $display("FAIL reset_otrig: got %b want 0", otrig); end
    n_checks++; if (trig_start !== 1'b0) begin n_fail++; $display("FAIL reset_trig_start: got %b want 0", trig_start); end
    n_checks++; if (trig_pattern !== 2'b00) begin n_fail++; $display("FAIL reset_pattern: got %b want 00", trig_pattern); end
    n_checks++; if (evt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_evt_cnt: got %0d want 0", evt_cnt); end
    n_checks++; if (lost_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_lost_cnt: got %0d want 0", lost_cnt); end
    rst_n = 1'b1;
    arm   = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (otrig !== 1'b0) begin n_fail++; $display("FAIL idle_otrig: got %b want 0", otrig); end
  endtask

  task automatic test_single();
    int len;
    set_samples(14'd1801, 14'd1000);
    @(negedge clk);
    tdat = baseline;
    n_checks++; if (otrig !== 1'b0) begin n_fail++; $display("FAIL single_lat_e0: got %b want 0", otrig); end
    @(negedge clk);
    n_checks++; if (otrig !== 1'b0) begin n_fail++; $display("FAIL single_lat_e1: got %b want 0", otrig); end
    @(negedge clk);
    n_checks++; if (otrig !== 1'b1) begin n_fail++; $display("FAIL single_lat_e2: got %b want 1", otrig); end
    n_checks++; if (trig_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", trig_start); end
    n_checks++; if (trig_pattern !== 2'b01) begin n_fail++; $display("FAIL single_pattern: got %b want 01", trig_pattern); end
    n_checks++; if (evt_cnt !== 16'd1) begin n_fail++; $display("FAIL single_evt_cnt: got %0d want 1", evt_cnt); end
    len = 1;
    @(negedge clk);
    n_checks++; if (trig_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b want 0", trig_start); end
    for (int i = 0; i < 200 && otrig; i++) begin len++; @(negedge clk); end
    n_checks++; if (len !== 70) begin n_fail++; $display("FAIL single_window_len: got %0d want 70", len); end
    settle();
  endtask

  task automatic test_threshold();
    logic seen;
    seen = 1'b0;
    set_samples(14'd1800, 14'd1000);
    @(negedge clk);
    tdat = baseline;
    repeat (6) begin @(negedge clk); seen |= otrig; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL thres_equal: got otrig %b want 0", seen); end
    seen = 1'b0;
    set_samples(14'd500, 14'd500);
    @(negedge clk);
    tdat = baseline;
    repeat (6) begin @(negedge clk); seen |= otrig; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL thres_below_base: got otrig %b want 0", seen); end
    n_checks++; if (evt_cnt !== 16'd1) begin n_fail++; $display("FAIL thres_evt_cnt: got %0d want 1", evt_cnt); end
  endtask

  task automatic test_mult();
    logic seen;
    mult = 4'd2;
    seen = 1'b0;
    set_samples(14'd1000, 14'd1801);
    @(negedge clk);
    tdat = baseline;
    repeat (6) begin @(negedge clk); seen |= otrig; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mult2_one_ch: got otrig %b want 0", seen); end
    set_samples(14'd1801, 14'd2000);
    @(negedge clk);
    tdat = baseline;
    repeat (2) @(negedge clk);
    n_checks++; if (otrig !== 1'b1) begin n_fail++; $display("FAIL mult2_both_otrig: got %b want 1", otrig); end
    n_checks++; if (trig_pattern !== 2'b11) begin n_fail++; $display("FAIL mult2_both_pattern: got %b want 11", trig_pattern); end
    n_checks++; if (evt_cnt !== 16'd2) begin n_fail++; $display("FAIL mult2_evt_cnt: got %0d want 2", evt_cnt); end
    settle();
    n_checks++; if (trig_pattern !== 2'b11) begin n_fail++; $display("FAIL pattern_hold: got %b want 11", trig_pattern); end
    ch_mask = 2'b01;
    seen = 1'b0;
    set_samples(14'd1801, 14'd1801);
    @(negedge clk);
    tdat = baseline;
    repeat (6) begin @(negedge clk); seen |= otrig; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mult_over_mask: got otrig %b want 0", seen); end
    ch_mask = 2'b11;
    mult    = 4'd0;
    set_samples(14'd1000, 14'd1801);
    @(negedge clk);
    tdat = baseline;
    repeat (2) @(negedge clk);
    n_checks++; if (otrig !== 1'b1) begin n_fail++; $display("FAIL mult0_otrig: got %b want 1", otrig); end
    n_checks++; if (trig_pattern !== 2'b10) begin n_fail++; $display("FAIL mult0_pattern: got %b want 10", trig_pattern); end
    n_checks++; if (evt_cnt !== 16'd3) begin n_fail++; $display("FAIL mult0_evt_cnt: got %0d want 3", evt_cnt); end
    mult = 4'd1;
    settle();
  endtask

  task automatic test_fifo_full();
    logic seen;
    seen      = 1'b0;
    fifo_full = 1'b1;
    for (int p = 0; p < 3; p++) begin
      set_samples(14'd1801, 14'd1000);
      @(negedge clk);
      seen |= otrig;
      tdat = baseline;
      repeat (4) begin @(negedge clk); seen |= otrig; end
    end
    repeat (3) begin @(negedge clk); seen |= otrig; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL full_otrig: got %b want 0", seen); end
    n_checks++; if (lost_cnt !== 16'd3) begin n_fail++; $display("FAIL full_lost_cnt: got %0d want 3", lost_cnt); end
    n_checks++; if (evt_cnt !== 16'd3) begin n_fail++; $display("FAIL full_evt_cnt: got %0d want 3", evt_cnt); end
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_retrig();
    int len;
    int starts;
    len    = 0;
    starts = 0;
    set_samples(14'd1801, 14'd1000);
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      if (otrig) len++;
      if (trig_start) starts++;
      if (i == 1 || i == 31) tdat = baseline;
      if (i == 30) set_samples(14'd1801, 14'd1000);
    end
    n_checks++; if (len !== RETRIG_LEN) begin n_fail++; $display("FAIL retrig_len: got %0d want %0d", len, RETRIG_LEN); end
    n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL retrig_starts: got %0d want 1", starts); end
    n_checks++; if (evt_cnt !== 16'd4) begin n_fail++; $display("FAIL retrig_evt_cnt: got %0d want 4", evt_cnt); end
    settle();
  endtask

  task automatic test_holdoff();
    int rises;
    int fall_i;
    int rise2_i;
    logic prev;
    rises   = 0;
    fall_i  = 0;
    rise2_i = 0;
    prev    = 1'b0;
    set_samples(14'd1801, 14'd1000);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) tdat = baseline;
      if (i == 76) set_samples(14'd1801, 14'd1000);
      if (otrig && !prev) begin
        rises++;
        if (rises == 2) begin rise2_i = i; tdat = baseline; end
      end
      if (!otrig && prev && rises == 1) fall_i = i;
      prev = otrig;
    end
    n_checks++; if (fall_i !== 73) begin n_fail++; $display("FAIL hold_first_fall: got %0d want 73", fall_i); end
    n_checks++; if (rise2_i - fall_i !== 17) begin n_fail++; $display("FAIL hold_gap: got %0d want 17", rise2_i - fall_i); end
    n_checks++; if (rises !== 2) begin n_fail++; $display("FAIL hold_rises: got %0d want 2", rises); end
    n_checks++; if (evt_cnt !== 16'd6) begin n_fail++; $display("FAIL hold_evt_cnt: got %0d want 6", evt_cnt); end
    n_checks++; if (lost_cnt !== 16'd3) begin n_fail++; $display("FAIL hold_lost_cnt: got %0d want 3", lost_cnt); end
    settle();
  endtask

  task automatic test_arm_hold();
    int len;
    logic seen;
    len = 0;
    set_samples(14'd1801, 14'd1000);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (otrig) len++;
      if (i == 1) tdat = baseline;
      if (i == 10) begin arm = 1'b0; fifo_full = 1'b1; end
    end
    n_checks++; if (len !== 70) begin n_fail++; $display("FAIL disarm_window_len: got %0d want 70", len); end
    n_checks++; if (lost_cnt !== 16'd3) begin n_fail++; $display("FAIL active_full_lost: got %0d want 3", lost_cnt); end
    n_checks++; if (evt_cnt !== 16'd7) begin n_fail++; $display("FAIL disarm_evt_cnt: got %0d want 7", evt_cnt); end
    fifo_full = 1'b0;
    seen = 1'b0;
    set_samples(14'd1801, 14'd1801);
    @(negedge clk);
    tdat = baseline;
    repeat (6) begin @(negedge clk); seen |= otrig; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL disarmed_trigger: got otrig %b want 0", seen); end
    arm = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_samples(14'd1801, 14'd1000);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) tdat = baseline;
    end
    n_checks++; if (otrig !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_otrig: got %b want 1", otrig); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (otrig !== 1'b0) begin n_fail++; $display("FAIL rstmid_otrig: got %b want 0", otrig); end
    n_checks++; if (evt_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_evt_cnt: got %0d want 0", evt_cnt); end
    n_checks++; if (lost_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_lost_cnt: got %0d want 0", lost_cnt); end
    n_checks++; if (trig_pattern !== 2'b00) begin n_fail++; $display("FAIL rstmid_pattern: got %b want 00", trig_pattern); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (otrig !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %b want 0", otrig); end
  endtask

  task automatic test_saturation();
    force dut.evt_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.evt_cnt_q;
    @(negedge clk);
    n_checks++; if (evt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preset: got %h want ffff", evt_cnt); end
    set_samples(14'd1801, 14'd1000);
    @(negedge clk);
    tdat = baseline;
    repeat (2) @(negedge clk);
    n_checks++; if (otrig !== 1'b1) begin n_fail++; $display("FAIL sat_otrig: got %b want 1", otrig); end
    @(negedge clk);
    n_checks++; if (evt_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_evt_cnt: got %h want ffff", evt_cnt); end
    settle();
  endtask

  initial begin
    rst_n     = 1'b0;
    arm       = 1'b0;
    ch_mask   = 2'b11;
    mult      = 4'd1;
    fifo_full = 1'b0;
    baseline  = {14'd1000, 14'd1000};
    tdat      = {14'd1000, 14'd1000};
    test_reset();
    test_single();
    test_threshold();
    test_mult();
    test_fifo_full();
    test_retrig();
    test_holdoff();
    test_arm_hold();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ch_trig.md
MULTI_CH_TRIG -- requirements
Module: multi_ch_trig

Interface
REQ-001 Parameter NCH, default 2: number of ADC channels, range 1..15.
REQ-002 Parameter DW, default 14: sample and baseline width in bits.
REQ-003 Parameter THRES, default 800: discriminator threshold above baseline, in ADC counts.
REQ-004 Parameter TRGTIME, default 70: trigger window length in clocks, range 1..65535.
REQ-005 Parameter HOLDOFF, default 16: dead time after each window in clocks, range 0..65535.
REQ-006 Port clk, input, 1 bit: single clock (ADC-domain clock).
REQ-007 Port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-008 Port arm, input, 1 bit: level enable for triggering.
REQ-009 Port ch_mask, input, NCH bits: 1 enables the channel in the coincidence.
REQ-010 Port mult, input, 4 bits: required number of coincident channels.
REQ-011 Port tdat, input, NCH*DW bits: samples; channel i occupies bits [i*DW +: DW].
REQ-012 Port baseline, input, NCH*DW bits: per-channel baselines, same packing as tdat.
REQ-013 Port fifo_full, input, 1 bit: downstream buffer full; inhibits new triggers.
REQ-014 Port otrig, output, 1 bit: trigger window active (FIFO write qualifier).
REQ-015 Port trig_start, output, 1 bit: one-clock pulse on the first window cycle.
REQ-016 Port trig_pattern, output, NCH bits: channels that fired for the current event.
REQ-017 Port evt_cnt, output, 16 bits: accepted triggers.
REQ-018 Port lost_cnt, output, 16 bits: triggers dropped by fifo_full.

Function
REQ-019 Channel i fire_r SHALL be registered as 1 when unsigned tdat_i minus baseline_i > THRES, with the subtraction at DW+1 bits; tdat_i <= baseline_i SHALL give 0.
REQ-020 Coincidence SHALL be popcount(fire_r AND ch_mask) >= max(mult,1); mult=0 SHALL act as 1.
REQ-021 Coincidence SHALL never occur when mult exceeds popcount(ch_mask).
REQ-022 The FSM SHALL have states IDLE, ARMED, ACTIVE and HOLD.
REQ-023 IDLE SHALL go to ARMED when arm=1.
REQ-024 ARMED SHALL go to IDLE when arm=0.
REQ-025 ARMED with coincidence and fifo_full=0 SHALL go to ACTIVE, increment evt_cnt, and latch trig_pattern = fire_r AND ch_mask.
REQ-026 ARMED with coincidence and fifo_full=1 SHALL stay in ARMED and increment lost_cnt.
REQ-027 Latency: a sample meeting threshold at clock edge k SHALL give otrig=1 and trig_start=1 after edge k+2.
REQ-028 otrig SHALL be 1 exactly TRGTIME clocks in ACTIVE; trig_start SHALL be 1 only on the first of them.
REQ-029 ACTIVE end SHALL go to HOLD for HOLDOFF clocks, or directly to ARMED/IDLE when HOLDOFF=0.
REQ-030 HOLD end SHALL go to ARMED if arm=1, else IDLE.
REQ-031 Deasserting arm during ACTIVE or HOLD SHALL NOT truncate them.
REQ-032 fifo_full during ACTIVE SHALL NOT affect the window.
REQ-033 Coincidences in HOLD SHALL be ignored and SHALL NOT be counted.
REQ-034 evt_cnt and lost_cnt SHALL saturate at 0xFFFF.
REQ-035 trig_pattern SHALL hold its value until the next accepted trigger.

Reset
REQ-036 While rst_n=0 at a clk edge, the block SHALL enter IDLE and clear to 0: otrig, trig_start, trig_pattern, evt_cnt, lost_cnt, fire_r and the window/holdoff counters.
REQ-037 Reset mid-window SHALL drop otrig on the edge that samples rst_n=0.

Configuration
REQ-038 With macro MULTI_CH_TRIG_RETRIG_EN defined, a coincidence in ACTIVE SHALL reload the window counter to TRGTIME and OR new channels into trig_pattern, with no evt_cnt increment and no trig_start.
REQ-039 With MULTI_CH_TRIG_RETRIG_EN undefined, coincidences in ACTIVE SHALL be ignored.

Verification
REQ-040 NCH=2, mask=11, mult=1, baseline=1000, arm=1, ch0 sample 1801 for one clock -> otrig high 70 clocks starting 2 clocks later, trig_start 1 clock, pattern=01, evt_cnt=1.
REQ-041 Same stimulus with ch0 sample 1800 -> no trigger; tdat=500 below baseline=1000 -> no trigger.
REQ-042 mult=2 with only ch1 firing -> no trigger; then both channels firing -> trigger, pattern=11.
REQ-043 fifo_full=1 and three single-clock pulses spaced 5 clocks apart while ARMED -> otrig stays 0, lost_cnt=3.
REQ-044 Second pulse 30 clocks into the window -> macro defined: otrig lasts 100 clocks total, evt_cnt=1; macro undefined: otrig lasts 70 clocks, then 16-clock HOLD, evt_cnt=1.
REQ-045 rst_n=0 at window cycle 10 -> otrig=0 on that edge, counters=0; preset evt_cnt=0xFFFF plus one more trigger -> evt_cnt stays 0xFFFF.
